// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the memory access stage.
// funct3 size codes, result-source and FSM state enums, word width.
package mem_stage_pkg;

  localparam int WORD_W = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } res_src_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_REQ  = 2'b01,
    S_WAIT = 2'b10
  } state_e;

endpackage

// File: rtl/load_store_align.sv
// Byte-lane alignment: store strobes/replicated data, load extract+extend.
// Ports: i_funct3, i_off, i_wdata, i_rdata -> o_wstrb, o_wdata, o_rdata.
module load_store_align
  import mem_stage_pkg::*;
(
  input  logic [2:0]        i_funct3,
  input  logic [1:0]        i_off,
  input  logic [WORD_W-1:0] i_wdata,
  input  logic [WORD_W-1:0] i_rdata,
  output logic [3:0]        o_wstrb,
  output logic [WORD_W-1:0] o_wdata,
  output logic [WORD_W-1:0] o_rdata
);

  logic              w_is_b;
  logic              w_is_h;
  logic              w_sgn;
  logic [1:0]        w_lane;
  logic [WORD_W-1:0] w_sh;

  assign w_is_b = (i_funct3 == F3_B) | (i_funct3 == F3_BU);
  assign w_is_h = (i_funct3 == F3_H) | (i_funct3 == F3_HU);
  assign w_sgn  = ~i_funct3[2];

  // Halfwords ignore off[0]; words always use lane 0.
  always_comb begin
    w_lane = 2'b00;
    if (w_is_b)      w_lane = i_off;
    else if (w_is_h) w_lane = {i_off[1], 1'b0};
  end

  assign w_sh = i_rdata >> {w_lane, 3'b000};

  always_comb begin
    o_wstrb = 4'b1111;
    o_wdata = i_wdata;
    o_rdata = w_sh;
    unique case (1'b1)
      w_is_b: begin
        o_wstrb = 4'b0001 << w_lane;
        o_wdata = {4{i_wdata[7:0]}};
        o_rdata = {{24{w_sgn & w_sh[7]}}, w_sh[7:0]};
      end
      w_is_h: begin
        o_wstrb = 4'b0011 << w_lane;
        o_wdata = {2{i_wdata[15:0]}};
        o_rdata = {{16{w_sgn & w_sh[15]}}, w_sh[15:0]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/memory_access_stage.sv
// M stage: runs loads/stores on a valid/ready bus, stalls, fills M->W reg.
// Optional MISALIGN_TRAP_EN adds MisalignW and traps misaligned H/W.
module memory_access_stage
  import mem_stage_pkg::*;
#(
  parameter int word_width = 32,
  parameter int strb_width = word_width / 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  RegWriteM,
  input  logic [1:0]            ResultSrcM,
  input  logic                  MemWriteM,
  input  logic [2:0]            funct3M,
  input  logic [word_width-1:0] ALUResultM,
  input  logic [word_width-1:0] WriteDataM,
  input  logic [4:0]            RdM,
  input  logic [word_width-1:0] PCPlus4M,
  output logic                  StallM,
  output logic                  dmem_req_valid,
  input  logic                  dmem_req_ready,
  output logic                  dmem_we,
  output logic [word_width-1:0] dmem_addr,
  output logic [word_width-1:0] dmem_wdata,
  output logic [strb_width-1:0] dmem_wstrb,
  input  logic                  dmem_rvalid,
  input  logic [word_width-1:0] dmem_rdata,
  output logic                  RegWriteW,
  output logic [1:0]            ResultSrcW,
  output logic [word_width-1:0] ALUResultW,
  output logic [word_width-1:0] ReadDataW,
  output logic [4:0]            RdW,
`ifdef MISALIGN_TRAP_EN
  output logic                  MisalignW,
`endif
  output logic [word_width-1:0] PCPlus4W
);

  state_e            r_state;
  logic              w_mem_op;
  logic              w_trap;
  logic              w_accept;
  logic              w_capture;
  logic              w_done;
  logic [3:0]        w_strb;
  logic [WORD_W-1:0] w_wdata;
  logic [WORD_W-1:0] w_rext;

  load_store_align u_align (
    .i_funct3 (funct3M),
    .i_off    (ALUResultM[1:0]),
    .i_wdata  (WriteDataM),
    .i_rdata  (dmem_rdata),
    .o_wstrb  (w_strb),
    .o_wdata  (w_wdata),
    .o_rdata  (w_rext)
  );

  assign w_mem_op = MemWriteM | (ResultSrcM == RES_MEM);

`ifdef MISALIGN_TRAP_EN
  logic w_hw;
  logic w_wd;
  assign w_hw = (funct3M == F3_H) | (funct3M == F3_HU);
  assign w_wd = ~w_hw & (funct3M != F3_B) & (funct3M != F3_BU);
  assign w_trap = w_mem_op
                & ((w_hw & ALUResultM[0])
                 | (w_wd & (ALUResultM[1:0] != 2'b00)));
`else
  assign w_trap = 1'b0;
`endif

  assign dmem_req_valid = ~reset & w_mem_op & ~w_trap
                        & (r_state != S_WAIT);
  assign w_accept  = dmem_req_valid & dmem_req_ready;
  assign w_capture = (r_state == S_WAIT) & dmem_rvalid;
  assign w_done    = (w_accept & MemWriteM) | w_capture;
  assign StallM    = ~reset & w_mem_op & ~w_trap & ~w_done;

  assign dmem_we    = MemWriteM;
  assign dmem_addr  = {ALUResultM[word_width-1:2], 2'b00};
  assign dmem_wdata = w_wdata;
  assign dmem_wstrb = MemWriteM ? w_strb : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      RegWriteW  <= 1'b0;
      ResultSrcW <= '0;
      ALUResultW <= '0;
      ReadDataW  <= '0;
      RdW        <= '0;
      PCPlus4W   <= '0;
`ifdef MISALIGN_TRAP_EN
      MisalignW  <= 1'b0;
`endif
    end else begin
      unique case (r_state)
        S_IDLE, S_REQ: begin
          if (dmem_req_valid) begin
            if (!w_accept)      r_state <= S_REQ;
            else if (MemWriteM) r_state <= S_IDLE;
            else                r_state <= S_WAIT;
          end
        end
        S_WAIT: if (dmem_rvalid) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
      // Stalled cycles push a bubble into W.
      RegWriteW  <= RegWriteM & ~StallM & ~w_trap;
      RdW        <= StallM ? 5'd0 : RdM;
      ResultSrcW <= ResultSrcM;
      ALUResultW <= ALUResultM;
      PCPlus4W   <= PCPlus4M;
      ReadDataW  <= w_capture ? w_rext : '0;
`ifdef MISALIGN_TRAP_EN
      MisalignW  <= w_trap;
`endif
    end
  end

endmodule

// File: tb/tb_memory_access_stage.sv
// Testbench for memory_access_stage: vector table, corner sequences,
// and random transactions against a byte-level reference model.
module tb_memory_access_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        RegWriteM;
  logic [1:0]  ResultSrcM;
  logic        MemWriteM;
  logic [2:0]  funct3M;
  logic [31:0] ALUResultM, WriteDataM, PCPlus4M;
  logic [4:0]  RdM;
  logic        StallM;
  logic        dmem_req_valid, dmem_req_ready, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_rvalid;
  logic        RegWriteW;
  logic [1:0]  ResultSrcW;
  logic [31:0] ALUResultW, ReadDataW, PCPlus4W;
  logic [4:0]  RdW;
`ifdef MISALIGN_TRAP_EN
  logic        MisalignW;
`endif

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  memory_access_stage dut (
    .clk(clk), .reset(reset),
    .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM),
    .MemWriteM(MemWriteM), .funct3M(funct3M),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
    .RdM(RdM), .PCPlus4M(PCPlus4M), .StallM(StallM),
    .dmem_req_valid(dmem_req_valid),
    .dmem_req_ready(dmem_req_ready), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_wstrb(dmem_wstrb), .dmem_rvalid(dmem_rvalid),
    .dmem_rdata(dmem_rdata), .RegWriteW(RegWriteW),
    .ResultSrcW(ResultSrcW), .ALUResultW(ALUResultW),
    .ReadDataW(ReadDataW), .RdW(RdW),
`ifdef MISALIGN_TRAP_EN
    .MisalignW(MisalignW),
`endif
    .PCPlus4W(PCPlus4W)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0]  strb;
    logic [31:0] wdata;
    logic [31:0] rext;
    bit          trap;
  } mdl_t;

  // Reference: size in bytes, lane from offset, arithmetic extension.
  function automatic mdl_t model(input int kind, input logic [2:0] f3,
                                 input logic [31:0] addr, wd, rdata);
    mdl_t m;
    int off, size, lane;
    bit sgn;
    longint v, lim;
    off  = int'(addr[1:0]);
    size = (f3 == 0 || f3 == 4) ? 1 : ((f3 == 1 || f3 == 5) ? 2 : 4);
    sgn  = (f3 == 0 || f3 == 1);
    m.trap = 0;
`ifdef MISALIGN_TRAP_EN
    m.trap = (kind != 0) &&
             ((size == 2 && off % 2 == 1) || (size == 4 && off != 0));
`endif
    lane = (size == 1) ? off : ((size == 2) ? (off / 2) * 2 : 0);
    m.strb = (kind == 2) ? 4'(((1 << size) - 1) << lane) : 4'h0;
    if (size == 1)      m.wdata = 32'(wd[7:0] * 32'h01010101);
    else if (size == 2) m.wdata = 32'(wd[15:0] * 32'h00010001);
    else                m.wdata = wd;
    lim = longint'(1) << (8 * size);
    v = longint'(rdata >> (8 * lane)) % lim;
    if (sgn && size < 4 && v >= lim / 2) v = v - lim;
    m.rext = 32'(v);
    return m;
  endfunction

  // kind: 0 ALU, 1 load, 2 store. Starts and ends 1 after a posedge.
  task automatic do_op(input int kind, input logic [2:0] f3,
                       input logic [31:0] addr, wd, rdata,
                       input int rdly, vdly, input logic [4:0] rd,
                       output logic [31:0] o_rd, output logic [3:0] o_strb,
                       output logic [31:0] o_wdata, output int stalls);
    mdl_t m;
    bit prev_st;
    m = model(kind, f3, addr, wd, rdata);
    RegWriteM  = (kind != 2);
    ResultSrcM = (kind == 1) ? 2'b01 : 2'b00;
    MemWriteM  = (kind == 2);
    funct3M    = f3;
    ALUResultM = addr;
    WriteDataM = wd;
    RdM        = rd;
    PCPlus4M   = addr ^ 32'h5A5A0004;
    stalls = 0; prev_st = 0;
    o_strb = 4'h0; o_wdata = '0;
    if (kind != 0 && !m.trap) begin
      for (int c = 0; c <= rdly; c++) begin
        dmem_req_ready = (c == rdly);
        #4;
        if (prev_st) chk("bubble_we", 32'(RegWriteW), 0);
        chk("req_valid", 32'(dmem_req_valid), 1);
        chk("req_we", 32'(dmem_we), 32'(kind == 2));
        chk("req_addr", dmem_addr, {addr[31:2], 2'b00});
        chk("req_strb", 32'(dmem_wstrb), 32'(m.strb));
        if (kind == 2) chk("req_wdata", dmem_wdata, m.wdata);
        o_strb = dmem_wstrb; o_wdata = dmem_wdata;
        prev_st = !(kind == 2 && c == rdly);
        chk("stall_req", 32'(StallM), 32'(prev_st));
        if (StallM) stalls++;
        @(posedge clk); #1;
        dmem_req_ready = 0;
      end
      if (kind == 1) begin
        for (int c = 1; c <= vdly; c++) begin
          dmem_rvalid = (c == vdly);
          dmem_rdata = (c == vdly) ? rdata : $urandom;
          #4;
          if (prev_st) chk("bubble_rd", 32'(RdW), 0);
          chk("wait_valid", 32'(dmem_req_valid), 0);
          prev_st = (c != vdly);
          chk("stall_wait", 32'(StallM), 32'(prev_st));
          if (StallM) stalls++;
          @(posedge clk); #1;
          dmem_rvalid = 0;
        end
      end
    end else begin
      dmem_rdata = $urandom;
      #4;
      chk("nobus_valid", 32'(dmem_req_valid), 0);
      chk("nobus_stall", 32'(StallM), 0);
      @(posedge clk); #1;
    end
    chk("w_regwrite", 32'(RegWriteW), 32'(kind != 2 && !m.trap));
    chk("w_rd", 32'(RdW), 32'(rd));
    chk("w_alu", ALUResultW, addr);
    chk("w_pc4", PCPlus4W, addr ^ 32'h5A5A0004);
    chk("w_src", 32'(ResultSrcW), 32'((kind == 1) ? 1 : 0));
    chk("w_rdata", ReadDataW,
        (kind == 1 && !m.trap) ? m.rext : 32'h0);
`ifdef MISALIGN_TRAP_EN
    chk("w_misalign", 32'(MisalignW), 32'(m.trap));
`endif
    o_rd = ReadDataW;
  endtask

  typedef struct {
    int          kind;
    logic [2:0]  f3;
    logic [31:0] addr, wd, rdata;
    int          rdly, vdly;
    logic [31:0] e_rd;
    logic [3:0]  e_strb;
    logic [31:0] e_wdata;
    int          e_stalls;
  } vec_t;

  vec_t tbl[$];
  logic [31:0] g_rd, g_wd;
  logic [3:0]  g_strb;
  int          g_st;

  initial begin
    reset = 1; RegWriteM = 0; ResultSrcM = 0; MemWriteM = 0;
    funct3M = 0; ALUResultM = 0; WriteDataM = 0; RdM = 0;
    PCPlus4M = 0; dmem_req_ready = 0; dmem_rvalid = 0;
    dmem_rdata = 0;
    repeat (2) @(posedge clk);
    #1; reset = 0;
    #4;
    chk("rst_regwrite", 32'(RegWriteW), 0);
    chk("rst_rdata", ReadDataW, 0);
    chk("rst_rd", 32'(RdW), 0);
    chk("rst_valid", 32'(dmem_req_valid), 0);
    chk("rst_stall", 32'(StallM), 0);
    @(posedge clk); #1;

    tbl.push_back('{0, 3'd0, 32'h1234, 0, 0, 0, 1, 0, 4'h0, 0, 0});
    tbl.push_back('{2, 3'd0, 32'h103, 32'hAB, 0, 0, 1,
                    0, 4'b1000, 32'hABABABAB, 0});
    tbl.push_back('{2, 3'd1, 32'h102, 32'h1234, 0, 1, 1,
                    0, 4'b1100, 32'h12341234, 1});
    tbl.push_back('{2, 3'd2, 32'h100, 32'hCAFEF00D, 0, 0, 1,
                    0, 4'b1111, 32'hCAFEF00D, 0});
    tbl.push_back('{1, 3'd0, 32'h102, 0, 32'h0080FF00, 2, 3,
                    32'hFFFFFF80, 4'h0, 0, 5});
    tbl.push_back('{1, 3'd4, 32'h102, 0, 32'h0080FF00, 2, 3,
                    32'h00000080, 4'h0, 0, 5});
    tbl.push_back('{1, 3'd1, 32'h102, 0, 32'h80010000, 0, 1,
                    32'hFFFF8001, 4'h0, 0, 1});
    tbl.push_back('{1, 3'd5, 32'h102, 0, 32'h80010000, 0, 1,
                    32'h00008001, 4'h0, 0, 1});
    tbl.push_back('{1, 3'd2, 32'h104, 0, 32'h89ABCDEF, 1, 2,
                    32'h89ABCDEF, 4'h0, 0, 3});
    tbl.push_back('{1, 3'd0, 32'h101, 0, 32'h00007F00, 0, 1,
                    32'h0000007F, 4'h0, 0, 1});

    foreach (tbl[i]) begin
      do_op(tbl[i].kind, tbl[i].f3, tbl[i].addr, tbl[i].wd,
            tbl[i].rdata, tbl[i].rdly, tbl[i].vdly, 5'd5,
            g_rd, g_strb, g_wd, g_st);
      chk("tbl_stalls", 32'(g_st), 32'(tbl[i].e_stalls));
      if (tbl[i].kind == 1) chk("tbl_rdata", g_rd, tbl[i].e_rd);
      if (tbl[i].kind == 2) begin
        chk("tbl_strb", 32'(g_strb), 32'(tbl[i].e_strb));
        chk("tbl_wdata", g_wd, tbl[i].e_wdata);
      end
    end

    // Misaligned word load.
    do_op(1, 3'd2, 32'h101, 0, 32'hDEADBEEF, 0, 1, 5'd7,
          g_rd, g_strb, g_wd, g_st);
`ifdef MISALIGN_TRAP_EN
    chk("mis_stalls", 32'(g_st), 0);
    chk("mis_rdata", g_rd, 32'h0);
`else
    chk("mis_strb", 32'(g_strb), 0);
    chk("mis_rdata", g_rd, 32'hDEADBEEF);
`endif

    // Reset while waiting for load data; late rvalid must be ignored.
    RegWriteM = 1; ResultSrcM = 2'b01; MemWriteM = 0; funct3M = 3'd2;
    ALUResultM = 32'h200; RdM = 5'd9; dmem_req_ready = 1;
    #4;
    chk("rw_valid", 32'(dmem_req_valid), 1);
    @(posedge clk); #1;
    dmem_req_ready = 0;
    #4;
    chk("rw_stall", 32'(StallM), 1);
    @(posedge clk); #1;
    reset = 1;
    RegWriteM = 0; ResultSrcM = 2'b00; RdM = 5'd0;
    #4;
    chk("rw_rst_stall", 32'(StallM), 0);
    @(posedge clk); #1;
    reset = 0;
    dmem_rvalid = 1; dmem_rdata = 32'h12345678;
    #4;
    chk("rw_late_valid", 32'(dmem_req_valid), 0);
    @(posedge clk); #1;
    dmem_rvalid = 0;
    chk("rw_regwrite", 32'(RegWriteW), 0);
    chk("rw_rdata", ReadDataW, 0);

    for (int i = 0; i < 40; i++) begin
      int k;
      logic [2:0] f;
      k = $urandom_range(0, 2);
      f = (k == 2) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
      do_op(k, f, $urandom & 32'hFFFF, $urandom, $urandom,
            $urandom_range(0, 3), $urandom_range(1, 3),
            5'($urandom_range(1, 31)), g_rd, g_strb, g_wd, g_st);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/memory_access_stage.md
Name: memory_access_stage

Overview:
- Pipeline stage between the E->M pipeline register and writeback.
- Consumes the M-stage control/data bundle and runs loads/stores on a ready/valid data-memory bus: byte-lane alignment, write strobes, load sign/zero extension.
- Stalls the pipeline while an access is outstanding; registers the result into the M->W pipeline register.

Parameters:
word_width, 32, datapath/address width; only 32 supported
strb_width, word_width/8, byte strobes per word

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
RegWriteM  in  1  register write enable from M register
ResultSrcM  in  2  00 ALU, 01 load data, 10 PC+4; 01 marks a load
MemWriteM  in  1  store request
funct3M  in  3  access size/sign
ALUResultM  in  word_width  effective address / ALU result
WriteDataM  in  word_width  store data (unaligned, lane 0)
RdM  in  5  destination register
PCPlus4M  in  word_width  PC+4
StallM  out  1  combinational; holds F/D/E/M stages
dmem_req_valid  out  1  bus request
dmem_req_ready  in  1  bus accepts request
dmem_we  out  1  1 store, 0 load
dmem_addr  out  word_width  word-aligned address
dmem_wdata  out  word_width  lane-replicated store data
dmem_wstrb  out  strb_width  byte enables
dmem_rvalid  in  1  load data valid
dmem_rdata  in  word_width  load data word
RegWriteW  out  1  to W
ResultSrcW  out  2  to W
ALUResultW  out  word_width  to W
ReadDataW  out  word_width  extended load data
RdW  out  5  to W
PCPlus4W  out  word_width  to W

Behaviour:
- Reset: state IDLE; dmem_req_valid 0; all W outputs 0; StallM 0.
- mem_op = MemWriteM | (ResultSrcM==01).
- Non-mem op: no bus activity; StallM 0; W register loads bundle at next edge (latency 1).
- FSM IDLE/REQ/WAIT_DATA:
  - IDLE with mem_op: dmem_req_valid=1 combinationally.
  - Accept (valid&ready) on a store: done this cycle, stay IDLE.
  - Accept on a load: go WAIT_DATA.
  - No accept: go REQ.
  - REQ: valid held with addr/wdata/wstrb/we stable until ready; then store->IDLE, load->WAIT_DATA.
  - WAIT_DATA: valid 0; on dmem_rvalid capture extended data into ReadDataW, go IDLE.
- Bus timing: rvalid earliest one cycle after acceptance; rvalid in IDLE/REQ ignored.
- StallM = mem_op & ~done; done = store accepted, or rvalid in WAIT_DATA.
- While StallM=1, W register loads a bubble (RegWriteW=0, RdW=0, other fields don't-care).
- Address/data alignment:
  - dmem_addr = {ALUResultM[31:2],2'b00}; off = ALUResultM[1:0].
  - SB: wstrb=0001<<off; wdata={4{byte}}.
  - SH: wstrb=0011<<off; wdata={2{half}}.
  - SW: wstrb=1111.
  - Loads: dmem_wstrb=0.
- Load extract: shift rdata right by 8*off.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW whole word.
  - Unused funct3 codes treated as LW/SW.
- Reset mid-access: FSM to IDLE; a late rvalid is ignored; no W write.

Optional Feature:
MISALIGN_TRAP_EN
- Defined: halfword with off[0]=1 or word with off!=0 suppresses the bus request, completes in one cycle with RegWriteW=0, and raises extra output MisalignW=1 for one W cycle; MisalignW resets to 0.
- Undefined: no MisalignW port; misaligned accesses are issued with offset low bits ignored (half uses off[1], word uses lane 0).

Decomposition:
- Package mem_stage_pkg:
  - funct3 constants F3_B/H/W/BU/HU.
  - ResultSrc enum (RES_ALU, RES_MEM, RES_PC4).
  - FSM state enum.
  - word_width default.
- Sub-module load_store_align (combinational): wstrb/wdata generation and load extraction/extension, reused by a future cache.

Test Plan:
- ALU op RdM=5, ALUResultM=0x1234, ready=1 -> no request; next cycle RegWriteW=1, ALUResultW=0x1234, StallM never 1.
- SB addr 0x103, WriteDataM=0xAB, ready=1 -> dmem_addr=0x100, wstrb=1000, wdata=0xABABABAB, StallM 0, done in 1 cycle.
- LB addr 0x102, ready after 2 cycles, rvalid 3 cycles later with rdata=0x0080FF00 -> StallM high 5 cycles, request held stable, ReadDataW=0xFFFFFF80 (as LBU: 0x00000080); bubbles (RegWriteW=0) during stall.
- LH addr 0x102 with rdata=0x8001_0000 -> ReadDataW=0xFFFF8001; LHU -> 0x00008001.
- Reset asserted in WAIT_DATA, rvalid arrives the cycle after reset -> IDLE, RegWriteW=0, ReadDataW=0, no capture.
- MISALIGN_TRAP_EN: LW addr 0x101 -> dmem_req_valid never 1, MisalignW=1 one cycle, RegWriteW=0; without the macro -> request at 0x100, wstrb 0000, word returned unshifted.
